riscv_dmem_slave: RTL and testbench
===================================

Name: riscv_dmem_slave

Overview:
- Data-memory responder for the RISC-V core's load/store port. It is the other end of the core's mem_addr/ddatout/rw/en/ddatin interface.
- Word-organised RAM with a registered read path and a one-entry posted-write buffer with read forwarding.
- Checks every access against the address window and flags out-of-window accesses.
- Byte and halfword lane selection, merging and alignment traps are done by the core. This block always returns and stores whole 32-bit words.

Parameters:
- BASE_ADDR, 32'h00000000: byte address of word 0.
- DEPTH, 1024: number of 32-bit words; must be a power of two.
- AW, 10: word-index width; equals log2(DEPTH).
- CNT_W, 16: width of the access counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address from the core; bits [1:0] ignored for indexing.
- ddatout  in  32  write data from the core (full merged word).
- rw  in  1  1 = write, 0 = read; qualified by en.
- en  in  1  access request, sampled every rising edge.
- ddatin  out  32  read data to the core.
- err  out  1  one-cycle pulse: previous access was outside the window.
- rd_count  out  CNT_W  number of accepted in-window reads.
- wr_count  out  CNT_W  number of accepted in-window writes.

Behaviour:
- Reset (rst=1 at an edge):
  - ddatin=0, err=0, rd_count=0, wr_count=0.
  - Write buffer invalidated. A pending write is discarded, not committed.
  - RAM contents are not reset.
  - Any en asserted in the same cycle as rst is ignored.
- Window check (combinational):
  - off = mem_addr - BASE_ADDR, 32-bit modulo arithmetic.
  - in_win = (mem_addr >= BASE_ADDR) && (off[31:AW+2] == 0).
  - idx = off[AW+1:2].
- Write buffer state: wb_valid, wb_idx[AW-1:0], wb_data[31:0].
- Every edge with wb_valid=1 commits: mem[wb_idx] <= wb_data. wb_valid then clears unless a new write is captured at that same edge.
- Write, accepted at edge N (en=1, rw=1, in_win=1):
  - wb_idx <= idx, wb_data <= ddatout, wb_valid <= 1.
  - Committed to the array at edge N+1.
  - A simultaneous commit of an older entry and capture of a new one is legal and required (back-to-back stores).
  - wr_count increments by 1 and wraps modulo 2^CNT_W.
  - ddatin unchanged.
- Read, accepted at edge N (en=1, rw=0, in_win=1):
  - ddatin is updated at edge N, so it is valid during cycle N+1. Read latency is 1.
  - Data source: if wb_valid && wb_idx==idx, use wb_data (forwarding). Otherwise use mem[idx].
  - rd_count increments by 1 and wraps.
- Out-of-window access at edge N:
  - No array access and no buffer update.
  - err <= 1 for exactly one cycle.
  - For a read, ddatin <= 0. For a write, ddatin is unchanged.
  - Counters are unchanged.
- Idle (en=0):
  - ddatin holds its last value.
  - err <= 0.
  - The buffer still drains.
- err is 0 on every edge that does not see an out-of-window access.
- Read of a word two or more cycles after its write returns the committed array value.
- Two reads of the same word with no intervening write return identical data.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 3 cycles with en=0 -> ddatin=0, err=0, rd_count=0, wr_count=0 throughout.
- Write/read: write 32'hDEADBEEF to BASE+8, idle 2 cycles, read BASE+8 -> ddatin=32'hDEADBEEF one cycle after the read edge; wr_count=1, rd_count=1.
- Forwarding: write 32'h12345678 to BASE+4, read BASE+4 on the very next cycle -> ddatin=32'h12345678. Also write 32'hA to BASE+0 and 32'hB to BASE+4 back-to-back, then read both -> 32'hA and 32'hB.
- Out of window: read BASE+4*DEPTH, and with BASE_ADDR=32'h1000 read 32'h0FFC -> err=1 for exactly one cycle each, ddatin=0, rd_count unchanged. Write to BASE+4*DEPTH, then read BASE+0 -> word 0 unaltered.
- Low-bit ignore: write 32'hCAFEF00D to BASE+12, read BASE+13, BASE+14 and BASE+15 -> each returns 32'hCAFEF00D.
- Reset mid-operation: write 32'h55AA55AA to BASE+16 (word 4, previously 32'h0), assert rst on the next edge, then read BASE+16 -> 32'h0 (pending write dropped); counters=0 after reset.

Source files
------------

// File: rtl/riscv_dmem_slave_if.sv
// Load/store bus between the RISC-V core (master) and the data memory (slave).
// Carries whole 32-bit words; byte lanes are handled inside the core.
interface riscv_dmem_slave_if;
    logic [31:0] mem_addr;
    logic [31:0] ddatout;
    logic        rw;
    logic        en;
    logic [31:0] ddatin;
    logic        err;

    modport master (
        output mem_addr, ddatout, rw, en,
        input  ddatin, err
    );

    modport slave (
        input  mem_addr, ddatout, rw, en,
        output ddatin, err
    );
endinterface

// File: rtl/riscv_dmem_slave.sv
// Word-organised data memory for the core's load/store port: registered reads,
// a one-entry posted-write buffer with read forwarding, and an address-window check.
module riscv_dmem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AW        = 10,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_dmem_slave_if.slave    bus,
    output logic [CNT_W-1:0]     rd_count,
    output logic [CNT_W-1:0]     wr_count
);

    logic [31:0]   mem [DEPTH];

    logic [31:0]   off;
    logic          in_win;
    logic [AW-1:0] idx;
    logic          unused_ok;

    logic          wb_valid;
    logic [AW-1:0] wb_idx;
    logic [31:0]   wb_data;

    logic          wr_acc;
    logic          rd_acc;
    logic          oow_acc;
    logic          fwd_hit;

    // Byte offset inside the window; the two lowest bits select a byte lane and
    // are irrelevant to a word memory.
    assign off       = bus.mem_addr - BASE_ADDR;
    assign in_win    = (bus.mem_addr >= BASE_ADDR) && (off[31:AW+2] == '0);
    assign idx       = off[AW+1:2];
    assign unused_ok = ^off[1:0];

    assign wr_acc  = bus.en &&  bus.rw && in_win;
    assign rd_acc  = bus.en && !bus.rw && in_win;
    assign oow_acc = bus.en && !in_win;
    assign fwd_hit = wb_valid && (wb_idx == idx);

    // NOTE: the array has no reset; only the buffer's valid bit is cleared, so a
    // pending write is dropped while RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wb_valid) begin
            mem[wb_idx] <= wb_data;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so the read of
    // mem[] and wb_* below sees the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            bus.ddatin <= '0;
            bus.err    <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            bus.err  <= oow_acc;
            wb_valid <= wr_acc;

            if (wr_acc) begin
                wb_idx   <= idx;
                wb_data  <= bus.ddatout;
                wr_count <= wr_count + 1'b1;
            end

            if (rd_acc) begin
                // The buffered word is newer than the array copy until it commits.
                bus.ddatin <= fwd_hit ? wb_data : mem[idx];
                rd_count   <= rd_count + 1'b1;
            end else if (oow_acc && !bus.rw) begin
                bus.ddatin <= '0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_slave.sv
// Scoreboard bench for riscv_dmem_slave: each access pushes its expected
// ddatin/err, which the scenario task pops and compares after the edge.
module tb_riscv_dmem_slave;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        logic        rst;
        logic        en;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } step_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;

    riscv_dmem_slave_if bus ();

    riscv_dmem_slave #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_fails  = 0;
    logic [31:0]      last_ddatin = '0;
    logic [CNT_W-1:0] exp_rd = '0;
    logic [CNT_W-1:0] exp_wr = '0;

    function automatic step_t mk(logic r, logic e, logic w, logic [31:0] a,
                                 logic [31:0] wd, logic [31:0] rd);
        step_t s;
        s.rst = r; s.en = e; s.rw = w; s.addr = a; s.wdata = wd; s.rdata = rd;
        return s;
    endfunction

    // Drives one cycle and pushes what the bus must show after that edge.
    task automatic access(input step_t s);
        exp_t e;
        logic win;
        win = (s.addr >= BASE) && ((s.addr - BASE) < 4 * DEPTH);
        e.addr = s.addr;
        e.err  = 1'b0;
        if (s.rst) begin
            last_ddatin = '0;
            exp_rd = '0;
            exp_wr = '0;
        end else if (s.en && !win) begin
            e.err = 1'b1;
            if (!s.rw) last_ddatin = '0;
        end else if (s.en && s.rw) begin
            exp_wr = exp_wr + 1'b1;
        end else if (s.en) begin
            last_ddatin = s.rdata;
            exp_rd = exp_rd + 1'b1;
        end
        e.data = last_ddatin;
        sb.push_back(e);
        rst          = s.rst;
        bus.en       = s.en;
        bus.rw       = s.rw;
        bus.mem_addr = s.addr;
        bus.ddatout  = s.wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(1, 0, 0, 0, 0, 0));
        steps.push_back(mk(1, 1, 1, BASE, 32'hFFFF_FFFF, 0));
        for (int i = 0; i < 3; i++) steps.push_back(mk(0, 0, 0, 0, 0, 0));
        foreach (steps[i]) begin
            access(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (bus.ddatin !== e.data || bus.err !== e.err ||
                rd_count !== '0 || wr_count !== '0) begin
                n_fails++;
                $display("FAIL reset[%0d]: ddatin=%h err=%b rd=%0d wr=%0d, expected ddatin=%h err=%b rd=0 wr=0",
                         i, bus.ddatin, bus.err, rd_count, wr_count, e.data, e.err);
            end
        end
    endtask

    task automatic test_write_read();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(0, 1, 1, BASE + 8, 32'hDEAD_BEEF, 0));
        steps.push_back(mk(0, 0, 0, 0, 0, 0));
        steps.push_back(mk(0, 0, 0, 0, 0, 0));
        steps.push_back(mk(0, 1, 0, BASE + 8, 0, 32'hDEAD_BEEF));
        steps.push_back(mk(0, 1, 0, BASE + 8, 0, 32'hDEAD_BEEF));
        foreach (steps[i]) begin
            access(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (bus.ddatin !== e.data || bus.err !== e.err) begin
                n_fails++;
                $display("FAIL write_read @%h: ddatin=%h err=%b, expected ddatin=%h err=%b",
                         e.addr, bus.ddatin, bus.err, e.data, e.err);
            end
        end
        n_checks++;
        if (rd_count !== exp_rd || wr_count !== exp_wr) begin
            n_fails++;
            $display("FAIL write_read counters: rd=%0d wr=%0d, expected rd=%0d wr=%0d",
                     rd_count, wr_count, exp_rd, exp_wr);
        end
    endtask

    task automatic test_forwarding();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(0, 1, 1, BASE + 4, 32'h1234_5678, 0));
        steps.push_back(mk(0, 1, 0, BASE + 4, 0, 32'h1234_5678));
        steps.push_back(mk(0, 1, 1, BASE + 0, 32'h0000_000A, 0));
        steps.push_back(mk(0, 1, 1, BASE + 4, 32'h0000_000B, 0));
        steps.push_back(mk(0, 1, 0, BASE + 0, 0, 32'h0000_000A));
        steps.push_back(mk(0, 1, 0, BASE + 4, 0, 32'h0000_000B));
        foreach (steps[i]) begin
            access(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (bus.ddatin !== e.data || bus.err !== e.err) begin
                n_fails++;
                $display("FAIL forwarding @%h: ddatin=%h err=%b, expected ddatin=%h err=%b",
                         e.addr, bus.ddatin, bus.err, e.data, e.err);
            end
        end
        n_checks++;
        if (rd_count !== exp_rd || wr_count !== exp_wr) begin
            n_fails++;
            $display("FAIL forwarding counters: rd=%0d wr=%0d, expected rd=%0d wr=%0d",
                     rd_count, wr_count, exp_rd, exp_wr);
        end
    endtask

    task automatic test_out_of_window();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(0, 1, 0, BASE + 4 * DEPTH, 0, 0));
        steps.push_back(mk(0, 0, 0, 0, 0, 0));
        steps.push_back(mk(0, 1, 0, 32'h0000_0FFC, 0, 0));
        steps.push_back(mk(0, 0, 0, 0, 0, 0));
        steps.push_back(mk(0, 1, 0, BASE + 4, 0, 32'h0000_000B));
        steps.push_back(mk(0, 1, 1, BASE + 4 * DEPTH, 32'hFFFF_FFFF, 0));
        steps.push_back(mk(0, 0, 0, 0, 0, 0));
        steps.push_back(mk(0, 1, 0, BASE + 0, 0, 32'h0000_000A));
        foreach (steps[i]) begin
            access(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (bus.ddatin !== e.data || bus.err !== e.err) begin
                n_fails++;
                $display("FAIL out_of_window @%h: ddatin=%h err=%b, expected ddatin=%h err=%b",
                         e.addr, bus.ddatin, bus.err, e.data, e.err);
            end
        end
        n_checks++;
        if (rd_count !== exp_rd || wr_count !== exp_wr) begin
            n_fails++;
            $display("FAIL out_of_window counters: rd=%0d wr=%0d, expected rd=%0d wr=%0d",
                     rd_count, wr_count, exp_rd, exp_wr);
        end
    endtask

    task automatic test_low_bits();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(0, 1, 1, BASE + 12, 32'hCAFE_F00D, 0));
        for (int b = 13; b <= 15; b++)
            steps.push_back(mk(0, 1, 0, BASE + b, 0, 32'hCAFE_F00D));
        foreach (steps[i]) begin
            access(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (bus.ddatin !== e.data || bus.err !== e.err) begin
                n_fails++;
                $display("FAIL low_bits @%h: ddatin=%h err=%b, expected ddatin=%h err=%b",
                         e.addr, bus.ddatin, bus.err, e.data, e.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk(0, 1, 1, BASE + 16, 32'h0000_0000, 0));
        steps.push_back(mk(0, 0, 0, 0, 0, 0));
        steps.push_back(mk(0, 0, 0, 0, 0, 0));
        steps.push_back(mk(0, 1, 1, BASE + 16, 32'h55AA_55AA, 0));
        steps.push_back(mk(1, 0, 0, 0, 0, 0));
        steps.push_back(mk(0, 0, 0, 0, 0, 0));
        steps.push_back(mk(0, 1, 0, BASE + 16, 0, 32'h0000_0000));
        steps.push_back(mk(0, 1, 0, BASE + 16, 0, 32'h0000_0000));
        foreach (steps[i]) begin
            access(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (bus.ddatin !== e.data || bus.err !== e.err ||
                rd_count !== exp_rd || wr_count !== exp_wr) begin
                n_fails++;
                $display("FAIL reset_mid[%0d]: ddatin=%h err=%b rd=%0d wr=%0d, expected ddatin=%h err=%b rd=%0d wr=%0d",
                         i, bus.ddatin, bus.err, rd_count, wr_count, e.data, e.err, exp_rd, exp_wr);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.rw       = 1'b0;
        bus.mem_addr = '0;
        bus.ddatout  = '0;
        #1;
        test_reset();
        test_write_read();
        test_forwarding();
        test_out_of_window();
        test_low_bits();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
